// File: rtl/rs_pkg.sv
// rs_pkg: shared widths, entry struct and sizing helper for the reservation-station bank.
package rs_pkg;
    localparam int ROB_IDX_W = 5;
    localparam int PRF_IDX_W = 6;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W:0]   rob_idx;
        logic [PRF_IDX_W-1:0] dest;
        logic [PRF_IDX_W-1:0] src1_tag;
        logic                 src1_rdy;
        logic [PRF_IDX_W-1:0] src2_tag;
        logic                 src2_rdy;
    } rs_ent_t;

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction
endpackage

// File: rtl/rs_issue_bank_entry.sv
// rs_entry: one reservation-station slot with CDB wakeup and issue-request generation.
module rs_entry
    import rs_pkg::*;
#(
    parameter int PKT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 squash_i,
    input  logic                 wr_en_i,
    input  rs_ent_t              wr_ent_i,
    input  logic [PKT_W-1:0]     wr_pkt_i,
    input  logic                 clr_i,
    input  logic                 cdb_valid_i,
    input  logic [PRF_IDX_W-1:0] cdb_tag_i,
    output logic                 valid_o,
    output logic [ROB_IDX_W:0]   rob_o,
    output logic [PRF_IDX_W-1:0] dest_o,
    output logic [PRF_IDX_W-1:0] src1_tag_o,
    output logic [PRF_IDX_W-1:0] src2_tag_o,
    output logic [PKT_W-1:0]     pkt_o,
    output logic                 req_o
);
    rs_ent_t          ent_q, ent_d;
    logic [PKT_W-1:0] pkt_q, pkt_d;

    always_comb begin
        ent_d = ent_q;
        pkt_d = pkt_q;
        if (cdb_valid_i && ent_q.valid && ent_q.src1_tag == cdb_tag_i) ent_d.src1_rdy = 1'b1;
        if (cdb_valid_i && ent_q.valid && ent_q.src2_tag == cdb_tag_i) ent_d.src2_rdy = 1'b1;
        if (clr_i) ent_d.valid = 1'b0;
        if (wr_en_i) begin
            ent_d = wr_ent_i;
            pkt_d = wr_pkt_i;
        end
        if (squash_i) ent_d.valid = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q <= '0;
            pkt_q <= '0;
        end else begin
            ent_q <= ent_d;
            pkt_q <= pkt_d;
        end
    end

    assign valid_o    = ent_q.valid;
    assign rob_o      = ent_q.rob_idx;
    assign dest_o     = ent_q.dest;
    assign src1_tag_o = ent_q.src1_tag;
    assign src2_tag_o = ent_q.src2_tag;
    assign pkt_o      = pkt_q;
    assign req_o      = ent_q.valid & ent_q.src1_rdy & ent_q.src2_rdy;
endmodule

// File: rtl/rs_issue_bank.sv
// rs_issue_bank: RS entry storage feeding an oldest-first select tree and a
// single-entry issue register handing off to one functional unit.
module rs_issue_bank
    import rs_pkg::*;
#(
    parameter int NUM_ENT = 8,
    parameter int PKT_W   = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              squash,
    input  logic                              dispatch_en,
    input  logic [ROB_IDX_W:0]                dispatch_rob_idx,
    input  logic [PRF_IDX_W-1:0]              dispatch_dest_tag,
    input  logic [PRF_IDX_W-1:0]              dispatch_src1_tag,
    input  logic [PRF_IDX_W-1:0]              dispatch_src2_tag,
    input  logic                              dispatch_src1_rdy,
    input  logic                              dispatch_src2_rdy,
    input  logic [PKT_W-1:0]                  dispatch_pkt,
    input  logic                              cdb_valid,
    input  logic [PRF_IDX_W-1:0]              cdb_tag,
    input  logic [NUM_ENT-1:0]                of_gnt,
    output logic [NUM_ENT-1:0]                rs_req,
    output logic [NUM_ENT-1:0][ROB_IDX_W:0]   rs_order,
    output logic                              rs_of_en,
    output logic                              rs_full,
    output logic [cnt_w(NUM_ENT)-1:0]         rs_free_cnt,
    input  logic                              fu_ready,
    output logic                              iss_valid,
    output logic [ROB_IDX_W:0]                iss_rob_idx,
    output logic [PRF_IDX_W-1:0]              iss_dest_tag,
    output logic [PRF_IDX_W-1:0]              iss_src1_tag,
    output logic [PRF_IDX_W-1:0]              iss_src2_tag,
    output logic [PKT_W-1:0]                  iss_pkt
);
    localparam int CNT_W = cnt_w(NUM_ENT);

    logic [NUM_ENT-1:0]   valid, free, wr_sel, clr;
    logic [PRF_IDX_W-1:0] dest [NUM_ENT];
    logic [PRF_IDX_W-1:0] s1 [NUM_ENT];
    logic [PRF_IDX_W-1:0] s2 [NUM_ENT];
    logic [PKT_W-1:0]     pkt [NUM_ENT];
    rs_ent_t              dsp_ent;

    logic                 iss_valid_q, iss_valid_d;
    logic [ROB_IDX_W:0]   iss_rob_q, iss_rob_d;
    logic [PRF_IDX_W-1:0] iss_dest_q, iss_dest_d, iss_s1_q, iss_s1_d, iss_s2_q, iss_s2_d;
    logic [PKT_W-1:0]     iss_pkt_q, iss_pkt_d;

    // Lowest free slot: isolate the least-significant set bit of the free mask.
    assign free     = ~valid;
    assign wr_sel   = free & (~free + 1'b1);
    assign rs_full  = &valid;
    assign rs_of_en = ~iss_valid_q | fu_ready;
    assign clr      = of_gnt & {NUM_ENT{rs_of_en}};

    always_comb begin
        dsp_ent          = '0;
        dsp_ent.valid    = 1'b1;
        dsp_ent.rob_idx  = dispatch_rob_idx;
        dsp_ent.dest     = dispatch_dest_tag;
        dsp_ent.src1_tag = dispatch_src1_tag;
        dsp_ent.src2_tag = dispatch_src2_tag;
        dsp_ent.src1_rdy = dispatch_src1_rdy | (cdb_valid && dispatch_src1_tag == cdb_tag);
        dsp_ent.src2_rdy = dispatch_src2_rdy | (cdb_valid && dispatch_src2_tag == cdb_tag);
    end

    for (genvar i = 0; i < NUM_ENT; i++) begin : g_ent
        rs_entry #(.PKT_W(PKT_W)) u_ent (
            .clk        (clk),
            .rst        (rst),
            .squash_i   (squash),
            .wr_en_i    (wr_sel[i] & dispatch_en & ~rs_full),
            .wr_ent_i   (dsp_ent),
            .wr_pkt_i   (dispatch_pkt),
            .clr_i      (clr[i]),
            .cdb_valid_i(cdb_valid),
            .cdb_tag_i  (cdb_tag),
            .valid_o    (valid[i]),
            .rob_o      (rs_order[i]),
            .dest_o     (dest[i]),
            .src1_tag_o (s1[i]),
            .src2_tag_o (s2[i]),
            .pkt_o      (pkt[i]),
            .req_o      (rs_req[i])
        );
    end

    always_comb begin
        rs_free_cnt = '0;
        for (int i = 0; i < NUM_ENT; i++) rs_free_cnt = rs_free_cnt + CNT_W'(free[i]);
    end

    always_comb begin
        iss_valid_d = iss_valid_q & ~fu_ready;
        iss_rob_d   = iss_rob_q;
        iss_dest_d  = iss_dest_q;
        iss_s1_d    = iss_s1_q;
        iss_s2_d    = iss_s2_q;
        iss_pkt_d   = iss_pkt_q;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (clr[i]) begin
                iss_valid_d = 1'b1;
                iss_rob_d   = rs_order[i];
                iss_dest_d  = dest[i];
                iss_s1_d    = s1[i];
                iss_s2_d    = s2[i];
                iss_pkt_d   = pkt[i];
            end
        end
        if (squash) iss_valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid_q <= 1'b0;
            iss_rob_q   <= '0;
            iss_dest_q  <= '0;
            iss_s1_q    <= '0;
            iss_s2_q    <= '0;
            iss_pkt_q   <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_rob_q   <= iss_rob_d;
            iss_dest_q  <= iss_dest_d;
            iss_s1_q    <= iss_s1_d;
            iss_s2_q    <= iss_s2_d;
            iss_pkt_q   <= iss_pkt_d;
        end
    end

    assign iss_valid    = iss_valid_q;
    assign iss_rob_idx  = iss_rob_q;
    assign iss_dest_tag = iss_dest_q;
    assign iss_src1_tag = iss_s1_q;
    assign iss_src2_tag = iss_s2_q;
    assign iss_pkt      = iss_pkt_q;

    // The select tree must grant at most one entry, and only one that is requesting.
    a_gnt_legal: assert property (@(posedge clk) disable iff (rst)
        $onehot0(of_gnt) && ((of_gnt & ~rs_req) == '0));
endmodule

// File: tb/tb_rs_issue_bank.sv
// tb_rs_issue_bank: randomized and directed checks of rs_issue_bank against an
// entry-list reference model with an oldest-first grant picker.
module tb_rs_issue_bank;
    import rs_pkg::*;
    localparam int N  = 8;
    localparam int PK = 32;
    localparam int RW = ROB_IDX_W + 1;
    localparam int TW = PRF_IDX_W;

    logic clk = 0, rst = 1, squash = 0, dispatch_en = 0, cdb_valid = 0, fu_ready = 1;
    logic [RW-1:0] dispatch_rob_idx = 0;
    logic [TW-1:0] dispatch_dest_tag = 0, dispatch_src1_tag = 0, dispatch_src2_tag = 0, cdb_tag = 0;
    logic dispatch_src1_rdy = 0, dispatch_src2_rdy = 0;
    logic [PK-1:0] dispatch_pkt = 0;
    logic [N-1:0] of_gnt = 0, rs_req;
    logic [N-1:0][RW-1:0] rs_order;
    logic rs_of_en, rs_full, iss_valid;
    logic [cnt_w(N)-1:0] rs_free_cnt;
    logic [RW-1:0] iss_rob_idx;
    logic [TW-1:0] iss_dest_tag, iss_src1_tag, iss_src2_tag;
    logic [PK-1:0] iss_pkt;

    int checks = 0, errors = 0;
    bit auto_gnt = 0;
    int rob_n = 0;

    // Reference model: list of live ops plus the op sitting in the issue slot.
    bit m_v[N], m_r1[N], m_r2[N];
    logic [RW-1:0] m_rob[N];
    logic [TW-1:0] m_dst[N], m_s1[N], m_s2[N];
    logic [PK-1:0] m_pkt[N];
    bit mi_v;
    logic [RW+3*TW+PK-1:0] mi_op;

    rs_issue_bank #(.NUM_ENT(N), .PKT_W(PK)) dut (
        .clk(clk), .rst(rst), .squash(squash), .dispatch_en(dispatch_en),
        .dispatch_rob_idx(dispatch_rob_idx), .dispatch_dest_tag(dispatch_dest_tag),
        .dispatch_src1_tag(dispatch_src1_tag), .dispatch_src2_tag(dispatch_src2_tag),
        .dispatch_src1_rdy(dispatch_src1_rdy), .dispatch_src2_rdy(dispatch_src2_rdy),
        .dispatch_pkt(dispatch_pkt), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .of_gnt(of_gnt), .rs_req(rs_req), .rs_order(rs_order), .rs_of_en(rs_of_en),
        .rs_full(rs_full), .rs_free_cnt(rs_free_cnt), .fu_ready(fu_ready),
        .iss_valid(iss_valid), .iss_rob_idx(iss_rob_idx), .iss_dest_tag(iss_dest_tag),
        .iss_src1_tag(iss_src1_tag), .iss_src2_tag(iss_src2_tag), .iss_pkt(iss_pkt)
    );

    always #5 clk = ~clk;

    function automatic bit older(input logic [RW-1:0] a, input logic [RW-1:0] b);
        return (a[RW-1] ^ b[RW-1]) ? (a[RW-2:0] > b[RW-2:0]) : (a[RW-2:0] < b[RW-2:0]);
    endfunction

    function automatic logic [N-1:0] m_req();
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[i] = m_v[i] && m_r1[i] && m_r2[i];
        return r;
    endfunction

    function automatic int m_free();
        int c = 0;
        for (int i = 0; i < N; i++) c += m_v[i] ? 0 : 1;
        return c;
    endfunction

    function automatic logic [N-1:0] pick();
        logic [N-1:0] r = m_req();
        int best = -1;
        if (mi_v && !fu_ready) return '0;
        for (int i = 0; i < N; i++)
            if (r[i] && (best < 0 || older(m_rob[i], m_rob[best]))) best = i;
        return best < 0 ? '0 : N'(1) << best;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_r1[i] = 0; m_r2[i] = 0;
            m_rob[i] = 0; m_dst[i] = 0; m_s1[i] = 0; m_s2[i] = 0; m_pkt[i] = 0;
        end
        mi_v = 0;
        mi_op = '0;
    endtask

    task automatic m_step();
        bit was_full = (m_free() == 0);
        bit of_en = !mi_v || fu_ready;
        int j = -1, g = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_v[i]) j = i;
        for (int i = 0; i < N; i++) if (of_gnt[i]) g = i;
        if (squash) begin
            for (int i = 0; i < N; i++) m_v[i] = 0;
            mi_v = 0;
            return;
        end
        for (int i = 0; i < N; i++)
            if (m_v[i] && cdb_valid) begin
                if (m_s1[i] == cdb_tag) m_r1[i] = 1;
                if (m_s2[i] == cdb_tag) m_r2[i] = 1;
            end
        if (of_en && g >= 0) begin
            mi_v = 1;
            mi_op = {m_rob[g], m_dst[g], m_s1[g], m_s2[g], m_pkt[g]};
            m_v[g] = 0;
        end else if (fu_ready) mi_v = 0;
        if (dispatch_en && !was_full && j >= 0) begin
            m_v[j] = 1; m_rob[j] = dispatch_rob_idx; m_dst[j] = dispatch_dest_tag;
            m_s1[j] = dispatch_src1_tag; m_s2[j] = dispatch_src2_tag; m_pkt[j] = dispatch_pkt;
            m_r1[j] = dispatch_src1_rdy || (cdb_valid && dispatch_src1_tag == cdb_tag);
            m_r2[j] = dispatch_src2_rdy || (cdb_valid && dispatch_src2_tag == cdb_tag);
        end
    endtask

    // One clock: pick a grant, compare every output with the model, then advance the model.
    task automatic tick();
        logic [N-1:0] er;
        @(negedge clk);
        if (auto_gnt) of_gnt = pick();
        er = m_req();
        checks++;
        if (rs_req !== er) begin errors++; $display("FAIL req got=%b exp=%b t=%0t", rs_req, er, $time); end
        checks++;
        if (rs_free_cnt !== m_free()) begin errors++; $display("FAIL free_cnt got=%0d exp=%0d t=%0t", rs_free_cnt, m_free(), $time); end
        checks++;
        if (rs_full !== (m_free() == 0)) begin errors++; $display("FAIL full got=%b exp=%b t=%0t", rs_full, m_free() == 0, $time); end
        checks++;
        if (rs_of_en !== (!mi_v || fu_ready)) begin errors++; $display("FAIL of_en got=%b exp=%b t=%0t", rs_of_en, !mi_v || fu_ready, $time); end
        checks++;
        if (iss_valid !== mi_v) begin errors++; $display("FAIL iss_valid got=%b exp=%b t=%0t", iss_valid, mi_v, $time); end
        if (mi_v) begin
            checks++;
            if ({iss_rob_idx, iss_dest_tag, iss_src1_tag, iss_src2_tag, iss_pkt} !== mi_op) begin
                errors++;
                $display("FAIL iss_op got=%h exp=%h t=%0t", {iss_rob_idx, iss_dest_tag, iss_src1_tag, iss_src2_tag, iss_pkt}, mi_op, $time);
            end
        end
        for (int i = 0; i < N; i++)
            if (m_v[i]) begin
                checks++;
                if (rs_order[i] !== m_rob[i]) begin errors++; $display("FAIL order[%0d] got=%0d exp=%0d", i, rs_order[i], m_rob[i]); end
            end
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic quiet();
        dispatch_en = 0; cdb_valid = 0; squash = 0; of_gnt = 0;
    endtask

    task automatic set_dsp(input logic [TW-1:0] s1, input bit r1, input logic [TW-1:0] s2, input bit r2);
        dispatch_en = 1;
        dispatch_rob_idx = RW'(rob_n);
        rob_n = (rob_n + 1) % (1 << RW);
        dispatch_dest_tag = TW'($urandom);
        dispatch_src1_tag = s1; dispatch_src1_rdy = r1;
        dispatch_src2_tag = s2; dispatch_src2_rdy = r2;
        dispatch_pkt = $urandom;
    endtask

    task automatic drain();
        quiet(); fu_ready = 1; auto_gnt = 1;
        repeat (N + 2) tick();
        auto_gnt = 0; of_gnt = 0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1; m_reset();
        #2;
        checks++;
        if ({iss_valid, rs_full, rs_req} !== '0 || rs_free_cnt !== N) begin
            errors++; $display("FAIL reset_flags got v=%b f=%b req=%b cnt=%0d exp 0 0 0 %0d", iss_valid, rs_full, rs_req, rs_free_cnt, N);
        end
        checks++;
        if ({iss_rob_idx, iss_dest_tag, iss_src1_tag, iss_src2_tag, iss_pkt} !== '0) begin
            errors++; $display("FAIL reset_iss got=%h exp=0", {iss_rob_idx, iss_dest_tag, iss_src1_tag, iss_src2_tag, iss_pkt});
        end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_fill_drain();
        logic [RW-1:0] seen[$];
        quiet(); fu_ready = 1; auto_gnt = 0; rob_n = 0;
        for (int k = 0; k < N; k++) begin
            set_dsp(TW'(1), 1, TW'(2), 1);
            tick();
        end
        quiet();
        checks++;
        if (rs_full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", rs_full); end
        auto_gnt = 1;
        for (int k = 0; k < N + 2; k++) begin
            tick();
            if (iss_valid) seen.push_back(iss_rob_idx);
        end
        auto_gnt = 0; of_gnt = 0;
        checks++;
        if (seen.size() != N) begin errors++; $display("FAIL drain_count got=%0d exp=%0d", seen.size(), N); end
        for (int k = 0; k < seen.size(); k++) begin
            checks++;
            if (seen[k] !== RW'(k)) begin errors++; $display("FAIL drain_order[%0d] got=%0d exp=%0d", k, seen[k], k); end
        end
        checks++;
        if (rs_free_cnt !== N) begin errors++; $display("FAIL drain_free got=%0d exp=%0d", rs_free_cnt, N); end
    endtask

    task automatic test_wakeup();
        quiet(); fu_ready = 1;
        set_dsp(TW'(5), 0, TW'(3), 1);
        tick();
        quiet();
        tick();
        cdb_valid = 1; cdb_tag = TW'(5);
        checks++;
        if (rs_req[0] !== 1'b0) begin errors++; $display("FAIL wake_before got=%b exp=0", rs_req[0]); end
        tick();
        quiet();
        checks++;
        if (rs_req[0] !== 1'b1) begin errors++; $display("FAIL wake_after got=%b exp=1", rs_req[0]); end
        of_gnt = 1;
        tick();
        of_gnt = 0;
        checks++;
        if (iss_valid !== 1'b1 || iss_src1_tag !== TW'(5)) begin
            errors++; $display("FAIL wake_issue got v=%b s1=%0d exp v=1 s1=5", iss_valid, iss_src1_tag);
        end
        tick();
    endtask

    task automatic test_same_cycle();
        quiet(); fu_ready = 1;
        set_dsp(TW'(4), 1, TW'(9), 0);
        cdb_valid = 1; cdb_tag = TW'(9);
        tick();
        quiet();
        checks++;
        if (rs_req[0] !== 1'b1) begin errors++; $display("FAIL same_cycle_req got=%b exp=1", rs_req[0]); end
        of_gnt = 1;
        tick();
        quiet();
        tick();
    endtask

    task automatic test_stall();
        logic [RW+3*TW+PK-1:0] held;
        logic [RW-1:0] second;
        quiet(); fu_ready = 1;
        set_dsp(TW'(1), 1, TW'(1), 1); tick();
        set_dsp(TW'(1), 1, TW'(1), 1); second = dispatch_rob_idx; tick();
        quiet(); of_gnt = 1; tick();
        of_gnt = 0; fu_ready = 0;
        held = {iss_rob_idx, iss_dest_tag, iss_src1_tag, iss_src2_tag, iss_pkt};
        repeat (3) begin
            tick();
            checks++;
            if (rs_of_en !== 1'b0 || iss_valid !== 1'b1 || rs_free_cnt !== N - 1 ||
                {iss_rob_idx, iss_dest_tag, iss_src1_tag, iss_src2_tag, iss_pkt} !== held) begin
                errors++; $display("FAIL stall_hold got en=%b v=%b cnt=%0d exp en=0 v=1 cnt=%0d", rs_of_en, iss_valid, rs_free_cnt, N - 1);
            end
        end
        fu_ready = 1; of_gnt = 2;
        tick();
        of_gnt = 0;
        checks++;
        if (iss_valid !== 1'b1 || iss_rob_idx !== second) begin
            errors++; $display("FAIL stall_resume got rob=%0d exp=%0d", iss_rob_idx, second);
        end
        tick();
    endtask

    task automatic test_full_grant();
        logic [RW-1:0] late;
        quiet(); fu_ready = 1;
        for (int k = 0; k < N; k++) begin set_dsp(TW'(1), 1, TW'(1), 1); tick(); end
        set_dsp(TW'(1), 1, TW'(1), 1);
        of_gnt = N'(8);
        tick();
        of_gnt = 0;
        checks++;
        if (rs_free_cnt !== 1) begin errors++; $display("FAIL full_ignore got=%0d exp=1", rs_free_cnt); end
        set_dsp(TW'(1), 1, TW'(1), 1);
        late = dispatch_rob_idx;
        tick();
        quiet();
        checks++;
        if (rs_full !== 1'b1 || rs_order[3] !== late) begin
            errors++; $display("FAIL full_reuse got full=%b ord3=%0d exp 1 %0d", rs_full, rs_order[3], late);
        end
        drain();
    endtask

    task automatic test_squash();
        quiet(); fu_ready = 1;
        for (int k = 0; k < 6; k++) begin set_dsp(TW'(1), 1, TW'(1), 1); tick(); end
        quiet(); of_gnt = 1; tick();
        squash = 1; of_gnt = 2; fu_ready = 0;
        set_dsp(TW'(1), 1, TW'(1), 1);
        tick();
        quiet(); fu_ready = 1;
        checks++;
        if (rs_free_cnt !== N || iss_valid !== 1'b0 || rs_req !== '0) begin
            errors++; $display("FAIL squash got cnt=%0d v=%b req=%b exp %0d 0 0", rs_free_cnt, iss_valid, rs_req, N);
        end
        tick();
    endtask

    task automatic test_random();
        auto_gnt = 1;
        for (int c = 0; c < 400; c++) begin
            quiet();
            if ($urandom_range(0, 9) < 7)
                set_dsp(TW'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
                        TW'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
            cdb_valid = $urandom_range(0, 1) == 1;
            cdb_tag = TW'($urandom_range(0, 15));
            fu_ready = $urandom_range(0, 3) != 0;
            squash = $urandom_range(0, 49) == 0;
            tick();
        end
        drain();
    endtask

    initial begin
        m_reset();
        test_reset();
        test_fill_drain();
        test_wakeup();
        test_same_cycle();
        test_stall();
        test_full_grant();
        test_squash();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
